// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the 16-bit accumulator CPU; one shared memory port for fetch and data.
// 3-4 cycles per instruction at zero wait; memory stalls on mem_ready, halting on bus timeout or illegal encodings.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [7:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    WB_ALU = 4'd4,
    MEM_RD = 4'd5,
    WB_LD  = 4'd6,
    MEM_WR = 4'd7,
    JMP    = 4'd8,
    BRZ    = 4'd9,
    HALT   = 4'd15
  } state_t;

  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [1:0]       code, code_nxt;
  logic             mem_state;
  logic             tmo;
  logic             func_ok;
  logic [2:0]       func_k;

  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign cnt_inc   = {1'b0, cnt} + 1'b1;
  // Fires on the wait cycle that brings the count to the limit; a same-cycle mem_ready wins.
  assign tmo       = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (cnt_inc >= LIMIT);

  always_comb begin
    func_ok = (func[7:5] == 3'b000);
    func_k  = 3'd0;
    case (func[4:0])
      5'b00001: func_k = 3'd0;
      5'b00010: func_k = 3'd1;
      5'b00100: func_k = 3'd2;
      5'b01000: func_k = 3'd3;
      5'b10000: func_k = 3'd4;
      default:  func_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
      code  <= 2'b00;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      // Any non-waiting cycle clears the count, so every memory state is entered with zero.
      if (mem_state && !mem_ready)
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    code_nxt   = code;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'd0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    fault_code = 2'b00;
    state_o    = 4'd0;
    if (!rst) begin
      state_o = state;
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            state_nxt = DECODE;
          end else if (tmo) begin
            state_nxt = HALT;
            code_nxt  = 2'b11;
          end
        end
        DECODE: begin
          case (opcode)
            4'b0000: state_nxt = MEM_RD;
            4'b0001: state_nxt = MEM_WR;
            4'b0010: state_nxt = JMP;
            4'b0100: state_nxt = BRZ;
            4'b1000: state_nxt = EXEC_R;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: state_nxt = EXEC_I;
            default: begin
              state_nxt = HALT;
              code_nxt  = 2'b01;
            end
          endcase
        end
        EXEC_R: begin
          if (func_ok) begin
            alu_src_a = 1'b1;
            alu_ctrl  = func_k;
            state_nxt = WB_ALU;
          end else begin
            state_nxt = HALT;
            code_nxt  = 2'b10;
          end
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = {1'b0, opcode[1:0]};
          state_nxt = WB_ALU;
        end
        WB_ALU: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
        MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            state_nxt = WB_LD;
          end else if (tmo) begin
            state_nxt = HALT;
            code_nxt  = 2'b11;
          end
        end
        WB_LD: begin
          reg_write  = 1'b1;
          wb_sel     = 1'b1;
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
        MEM_WR: begin
          iord      = 1'b1;
          // The write is withdrawn in the faulting cycle so a timed-out store never commits.
          mem_write = !tmo;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_nxt  = FETCH;
          end else if (tmo) begin
            state_nxt = HALT;
            code_nxt  = 2'b11;
          end
        end
        JMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b01;
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
        BRZ: begin
          pc_src     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
        HALT: begin
          fault      = 1'b1;
          fault_code = code;
        end
        default: state_nxt = HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its list of steps and memory waits, and every cycle is checked.
module tb_multicycle_controller;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [7:0] func = 8'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, fault_code;
  logic       alu_src_a, reg_write, wb_sel, instr_done, fault;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
  logic [18:0] outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
    .fault(fault), .fault_code(fault_code), .state_o(state_o)
  );

  assign outs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_ctrl, reg_write, wb_sel, instr_done, fault, fault_code};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] ov(input logic mr, input logic mw, input logic io, input logic irw,
                                     input logic pcw, input logic [1:0] ps, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] ac, input logic rw,
                                     input logic wb, input logic dn, input logic f, input logic [1:0] fc);
    return {mr, mw, io, irw, pcw, ps, asa, asb, ac, rw, wb, dn, f, fc};
  endfunction

  // Index of the single set bit in func[4:0], or -1 when the function field is not legal.
  function automatic int func_index(input logic [7:0] fn);
    int n = 0;
    int k = -1;
    if (fn[7:5] != 3'b000) return -1;
    for (int i = 0; i < 5; i++) if (fn[i]) begin n++; k = i; end
    return (n == 1) ? k : -1;
  endfunction

  task automatic tick(input logic [3:0] st, input logic [18:0] ev);
    @(negedge clk);
    check("state", 32'(state_o), 32'(st));
    check("outs", 32'(outs), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      tick(4'd0, '0);
    end
    rst = 1'b0;
  endtask

  task automatic halt(input logic [1:0] code);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      tick(4'd15, ov(0,0,0,0,0,2'b00,0,2'b00,3'd0,0,0,0,1,code));
    end
    do_reset(1 + int'($urandom_range(0, 1)));
  endtask

  // A memory step waits w cycles before mem_ready; the 15th consecutive unready cycle is a bus fault.
  task automatic mem_step(input logic [3:0] st, input int w, output bit faulted);
    logic rdy, to;
    logic [18:0] ev;
    faulted = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rdy = (c >= w);
      to  = !rdy && (c == TMO - 1);
      mem_ready = rdy;
      case (st)
        4'd0:    ev = ov(1,0,0,rdy,rdy,2'b00,0,rdy ? 2'b01 : 2'b00,3'd0,0,0,0,0,2'b00);
        4'd5:    ev = ov(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0,2'b00);
        default: ev = ov(0,!to,1,0,0,2'b00,0,2'b00,3'd0,0,0,rdy,0,2'b00);
      endcase
      tick(st, ev);
      if (rdy) return;
      if (to) begin
        faulted = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [7:0] fn, input int wf, input int wm,
                           input logic zv);
    bit flt;
    int k;
    opcode = op;
    func = fn;
    mem_step(4'd0, wf, flt);
    if (flt) begin halt(2'b11); return; end
    mem_ready = 1'($urandom);
    tick(4'd1, '0);
    case (op)
      4'b0000: begin
        mem_step(4'd5, wm, flt);
        if (flt) begin halt(2'b11); return; end
        mem_ready = 1'($urandom);
        tick(4'd6, ov(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,1,1,0,2'b00));
      end
      4'b0001: begin
        mem_step(4'd7, wm, flt);
        if (flt) begin halt(2'b11); return; end
      end
      4'b0010: begin
        mem_ready = 1'($urandom);
        tick(4'd8, ov(0,0,0,0,1,2'b01,0,2'b00,3'd0,0,0,1,0,2'b00));
      end
      4'b0100: begin
        zero = zv;
        mem_ready = 1'($urandom);
        tick(4'd9, ov(0,0,0,0,zv,2'b01,0,2'b00,3'd0,0,0,1,0,2'b00));
      end
      4'b1000: begin
        k = func_index(fn);
        mem_ready = 1'($urandom);
        if (k < 0) begin
          tick(4'd2, '0);
          halt(2'b10);
          return;
        end
        tick(4'd2, ov(0,0,0,0,0,2'b00,1,2'b00,3'(k),0,0,0,0,2'b00));
        tick(4'd4, ov(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,0,1,0,2'b00));
      end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        mem_ready = 1'($urandom);
        tick(4'd3, ov(0,0,0,0,0,2'b00,1,2'b10,{1'b0, op[1:0]},0,0,0,0,2'b00));
        tick(4'd4, ov(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,0,1,0,2'b00));
      end
      default: halt(2'b01);
    endcase
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 29));
    if (r == 0) return 20;
    if (r == 1) return TMO - 1;
    if (r == 2) return TMO - 2;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [3:0] illegal [7] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB};
    logic [3:0] op;
    logic [7:0] fn;
    do_reset(2);

    // LOAD interrupted by reset while waiting in MEM_RD
    opcode = 4'h0;
    mem_ready = 1'b1;
    tick(4'd0, ov(1,0,0,1,1,2'b00,0,2'b01,3'd0,0,0,0,0,2'b00));
    mem_ready = 1'b0;
    tick(4'd1, '0);
    tick(4'd5, ov(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0,2'b00));
    tick(4'd5, ov(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0,2'b00));
    do_reset(3);
    // A stale wait count would fault this fetch, which only gets ready on its 15th cycle.
    run_instr(4'hC, 8'h00, TMO - 1, 0, 1'b0);

    run_instr(4'hC, 8'h00, 0, 0, 1'b0);
    run_instr(4'h0, 8'h00, 0, 3, 1'b0);
    run_instr(4'h4, 8'h00, 0, 0, 1'b1);
    run_instr(4'h4, 8'h00, 0, 0, 1'b0);
    run_instr(4'h8, 8'b0000_0110, 0, 0, 1'b0);
    run_instr(4'h2, 8'h00, 20, 0, 1'b0);
    run_instr(4'h1, 8'h00, 1, 20, 1'b0);
    run_instr(4'h0, 8'h00, 0, 20, 1'b0);
    run_instr(4'h8, 8'b0001_0000, 0, 0, 1'b0);
    run_instr(4'h8, 8'b0010_0001, 0, 0, 1'b0);
    run_instr(4'h6, 8'h00, 0, 0, 1'b0);
    run_instr(4'h1, 8'h00, 2, TMO - 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = illegal[$urandom_range(0, 6)];
      else op = legal[$urandom_range(0, 8)];
      if ($urandom_range(0, 4) == 0) fn = 8'($urandom);
      else fn = 8'(1 << $urandom_range(0, 4));
      run_instr(op, fn, pick_wait(), pick_wait(), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle sequencing FSM for the 16-bit accumulator-style processor. It replaces the single-cycle ControlUnit/ALUController pair. It drives every datapath strobe over several states per instruction and shares one single-port memory between instruction fetch and data access. Memory waits use a ready handshake guarded by a timeout. The block halts on illegal encodings or a bus timeout.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles per memory access before bus fault; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  4  IR[15:12], valid from DECODE onward
func  in  8  IR[7:0], one-hot R-type function
zero  in  1  datapath flag, R0==0
mem_ready  in  1  memory completes the current read/write this cycle
mem_read  out  1  memory read strobe, held until mem_ready
mem_write  out  1  memory write strobe, held until mem_ready
iord  out  1  address mux: 0=PC, 1=IR[11:0]
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC
pc_src  out  2  00=ALU result, 01={PC[15:12],IR[11:0]}
alu_src_a  out  1  0=PC, 1=R0
alu_src_b  out  2  00=Rn (IR[11:9]), 01=const 1, 10=zero-extended IR[11:0]
alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 not A
reg_write  out  1  write R0
wb_sel  out  1  0=ALU out register, 1=memory data register
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
fault  out  1  sticky halt indicator
fault_code  out  2  00 none, 01 illegal opcode, 10 illegal func, 11 bus timeout
state_o  out  4  current state, for debug and verification

Behaviour:
- Reset: while rst=1, every output is 0 and state_o=0. On the first clock with rst=0 the state is FETCH. Reset mid-instruction or while in HALT aborts immediately, clears the fault, and zeroes the wait counter.
- State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, MEM_RD=5, WB_LD=6, MEM_WR=7, JMP=8, BRZ=9, HALT=15.
- Outputs are Moore-decoded from state, except where a strobe is gated by mem_ready or zero as stated below.
- FETCH:
  - Drives iord=0, mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no strobes. Next state by opcode:
  - 0000 LOAD -> MEM_RD
  - 0001 STORE -> MEM_WR
  - 0010 JUMP -> JMP
  - 0100 BRZ -> BRZ
  - 1000 R-type -> EXEC_R
  - 1100/1101/1110/1111 ADDI/SUBI/ANDI/ORI -> EXEC_I
  - any other opcode -> HALT with fault_code=01
- EXEC_R:
  - func must be exactly one-hot in bits[4:0] with bits[7:5]=0; otherwise -> HALT with fault_code=10.
  - Bit k selects alu_ctrl=k. Drives alu_src_a=1, alu_src_b=00, then goes to WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl = opcode[1:0] zero-extended (add/sub/and/or), then goes to WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0, instr_done=1, then goes to FETCH.
- MEM_RD: iord=1, mem_read=1. On mem_ready, go to WB_LD.
- WB_LD: reg_write=1, wb_sel=1, instr_done=1, then goes to FETCH.
- MEM_WR: iord=1, mem_write=1. On mem_ready, instr_done=1, then goes to FETCH.
- JMP: pc_write=1, pc_src=01, instr_done=1, then goes to FETCH.
- BRZ: pc_src=01, pc_write=zero, instr_done=1, then goes to FETCH.
- Zero-wait memory latency: LOAD 4 cycles, R/I-type 4, STORE 3, JUMP 3, BRZ 3.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR, and on any mem_ready.
  - Increments each cycle the block is in those states with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT while mem_ready=0 -> HALT with fault_code=11.
  - mem_ready arriving in the same cycle the counter hits the limit wins: no fault.
  - The counter saturates and never wraps.
- HALT: all strobes 0, fault=1, and fault_code held. Only rst exits HALT.
- No pc_write, reg_write, ir_write or mem_write is ever asserted in the cycle a fault is detected.
- mem_read and mem_write are never asserted together. mem_ready outside a memory state is ignored.

Test Plan:
- Reset held 3 cycles during MEM_RD with mem_read=1 -> all outputs 0 while rst=1; state_o=0 on the first clock after release.
- ADDI (opcode 1100), mem_ready tied 1 -> state sequence 0,1,3,4; alu_ctrl=000, alu_src_b=10; reg_write and instr_done high only in state 4; 4 cycles total.
- LOAD with mem_ready low for 3 cycles in MEM_RD, MEM_TIMEOUT=15 -> mem_read and iord=1 held for 4 cycles; WB_LD with wb_sel=1; fault=0.
- BRZ twice, zero=1 then zero=0 -> pc_write=1 with pc_src=01 in the first BRZ cycle only; both instructions pulse instr_done.
- R-type with func=8'b0000_0110 -> HALT, fault_code=10, reg_write never asserted; stays in HALT until rst.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=15 -> HALT after exactly 15 wait cycles with fault_code=11; a repeat run with mem_ready on the 15th cycle -> no fault.
